bbox_detect: RTL

BBOX_DETECT -- requirements
Module: bbox_detect

---
 rtl/bbox_detect.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bbox_detect.sv
// Bounding-box detector: tracks the extent of above-threshold pixels per frame and reports it once per vsync rise.
// Define BBOX_OVERLAY_EN to draw the last reported box onto the delayed video stream.
`timescale 1ns/1ps

module bbox_detect #(
    parameter int             DW        = 24,
    parameter logic [7:0]     THRESH    = 8'd128,
    parameter logic [DW-1:0]  BOX_COLOR = {DW{1'b1}}
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    input  logic [DW-1:0] i_data,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [11:0]   i_hcount,
    input  logic [11:0]   i_vcount,
    output logic [DW-1:0] o_data,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [11:0]   o_xmin,
    output logic [11:0]   o_xmax,
    output logic [11:0]   o_ymin,
    output logic [11:0]   o_ymax,
    output logic          o_found,
    output logic          o_valid
);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        REPORT
    } state_t;

    state_t        state, state_next;
    logic          vsync_q;
    logic          boundary;
    logic          foreground;
    logic [11:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic          acc_hit;
    logic [DW-1:0] data_q;

    assign boundary   = i_vsync & ~vsync_q;
    assign foreground = i_de && (i_data[DW-1 -: 8] >= THRESH);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= WAIT_FRAME;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_next;
            vsync_q <= i_vsync;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: if (boundary) state_next = ACCUM;
            ACCUM:      if (boundary) state_next = REPORT;
            REPORT:     state_next = ACCUM;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    // Accumulators restart on entry to a fresh frame; the boundary-cycle pixel never updates them.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            acc_xmin <= 12'hFFF;
            acc_xmax <= 12'h000;
            acc_ymin <= 12'hFFF;
            acc_ymax <= 12'h000;
            acc_hit  <= 1'b0;
        end else if ((state == WAIT_FRAME && boundary) || state == REPORT) begin
            acc_xmin <= 12'hFFF;
            acc_xmax <= 12'h000;
            acc_ymin <= 12'hFFF;
            acc_ymax <= 12'h000;
            acc_hit  <= 1'b0;
        end else if (state == ACCUM && !boundary && foreground) begin
            if (i_hcount < acc_xmin) acc_xmin <= i_hcount;
            if (i_hcount > acc_xmax) acc_xmax <= i_hcount;
            if (i_vcount < acc_ymin) acc_ymin <= i_vcount;
            if (i_vcount > acc_ymax) acc_ymax <= i_vcount;
            acc_hit <= 1'b1;
        end
    end

    // Results are latched on the edge into REPORT so they are already valid while o_valid is high.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid <= 1'b0;
            o_found <= 1'b0;
            o_xmin  <= '0;
            o_xmax  <= '0;
            o_ymin  <= '0;
            o_ymax  <= '0;
        end else begin
            o_valid <= (state == ACCUM) && boundary;
            if (state == ACCUM && boundary) begin
                o_found <= acc_hit;
                o_xmin  <= acc_hit ? acc_xmin : 12'h000;
                o_xmax  <= acc_hit ? acc_xmax : 12'h000;
                o_ymin  <= acc_hit ? acc_ymin : 12'h000;
                o_ymax  <= acc_hit ? acc_ymax : 12'h000;
            end
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
            data_q  <= '0;
        end else begin
            o_hsync <= i_hsync;
            o_vsync <= i_vsync;
            o_de    <= i_de;
            data_q  <= i_de ? i_data : '0;
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic [11:0] hcount_q, vcount_q;
    logic        on_box;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= i_hcount;
            vcount_q <= i_vcount;
        end
    end

    // Rectangle outline test uses the delayed coordinates against the currently held box.
    always_comb begin
        on_box = 1'b0;
        if (o_de && o_found) begin
            if (hcount_q >= o_xmin && hcount_q <= o_xmax &&
                (vcount_q == o_ymin || vcount_q == o_ymax))
                on_box = 1'b1;
            if (vcount_q >= o_ymin && vcount_q <= o_ymax &&
                (hcount_q == o_xmin || hcount_q == o_xmax))
                on_box = 1'b1;
        end
    end

    assign o_data = on_box ? BOX_COLOR : data_q;
`else
    assign o_data = data_q;
`endif

endmodule
